// File: rtl/period_avg_pkg.sv
// Shared types and default widths for the period averager.
//   state_e  : averaging FSM state (StFill while the window fills, StTrack once it is full)
//   DefPw    : default period width in clock counts
//   DefLog2N : default log2 of the averaging window depth
package period_avg_pkg;

  localparam int unsigned DefPw    = 18;
  localparam int unsigned DefLog2N = 3;

  typedef enum logic [0:0] {
    StFill,
    StTrack
  } state_e;

endpackage

// File: rtl/period_averager_if.sv
// Measurement/result bundle between the frequency detector, the averager and the
// frequency-control stage.
//   master : drives period_in/period_valid, observes the filtered result
//   slave  : the averager; consumes samples, drives period_out/period_out_valid/stable/reject_cnt
interface period_averager_if
  import period_avg_pkg::*;
#(
  parameter int unsigned PW = DefPw
);
  logic [PW-1:0] period_in;
  logic          period_valid;
  logic [PW-1:0] period_out;
  logic          period_out_valid;
  logic          stable;
  logic [7:0]    reject_cnt;

  modport master (
    output period_in,
    output period_valid,
    input  period_out,
    input  period_out_valid,
    input  stable,
    input  reject_cnt
  );

  modport slave (
    input  period_in,
    input  period_valid,
    output period_out,
    output period_out_valid,
    output stable,
    output reject_cnt
  );
endinterface

// File: rtl/period_ring_buffer.sv
// Circular store of the last 2^Log2Depth accepted period samples.
//   clk_i    : clock
//   rst_ni   : synchronous active-low reset
//   clr_i    : synchronous clear of all entries and the write pointer
//   we_i     : write wdata_i at the write pointer and advance it
//   wdata_i  : sample to store
//   oldest_o : entry the next write will overwrite (zero until the store has wrapped)
module period_ring_buffer #(
  parameter int unsigned Width     = 18,
  parameter int unsigned Log2Depth = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             we_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] oldest_o
);
  localparam int unsigned Depth = 1 << Log2Depth;

  logic [Width-1:0]     mem_q [Depth];
  logic [Width-1:0]     mem_d [Depth];
  logic [Log2Depth-1:0] ptr_q, ptr_d;

  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    if (we_i) begin
      mem_d[ptr_q] = wdata_i;
      ptr_d        = ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      ptr_q <= '0;
    end else begin
      mem_q <= mem_d;
      ptr_q <= ptr_d;
    end
  end

  assign oldest_o = mem_q[ptr_q];

endmodule

// File: rtl/period_averager.sv
// Sliding-window period filter: moving average over 2^LOG2_N raw period samples with
// outlier rejection and a settled flag.
//   clk, rst_n : clock, synchronous active-low reset (priority over en)
//   en         : low = synchronous clear to reset state
//   bus        : period_averager_if.slave (period_in/valid in; period_out/valid, stable,
//                reject_cnt out)
// Build option: define PERIOD_AVG_OUTLIER_EN to enable the tolerance check, reject counting
// and relock; otherwise every nonzero sample is accepted.
// Pipeline: capture (t) -> decide/ring write/sum (t+1) -> outputs (t+2); strobes while
// busy are dropped.
module period_averager
  import period_avg_pkg::*;
#(
  parameter int unsigned PW         = DefPw,
  parameter int unsigned LOG2_N     = DefLog2N,
  parameter int unsigned TOL_SHIFT  = 4,
  parameter int unsigned STABLE_CNT = 4
) (
  input logic              clk,
  input logic              rst_n,
  input logic              en,
  period_averager_if.slave bus
);
  localparam int unsigned N  = 1 << LOG2_N;
  localparam int unsigned SW = PW + LOG2_N;
`ifdef PERIOD_AVG_OUTLIER_EN
  localparam bit OutlierEn = 1'b1;
`else
  localparam bit OutlierEn = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [SW-1:0]     sum_q, sum_d;
  logic [LOG2_N-1:0] fill_cnt_q, fill_cnt_d;
  logic [7:0]        acc_run_q, acc_run_d;
  logic [7:0]        rej_run_q, rej_run_d;
  // Stage 1 (decide) and stage 2 (publish) occupancy plus what stage 2 must do.
  logic              s1_q, s1_d, s2_q, s2_d;
  logic [PW-1:0]     cap_q, cap_d;
  logic              upd_q, upd_d, rej_q, rej_d, set_stable_q, set_stable_d;
  logic [PW-1:0]     period_out_q, period_out_d;
  logic              valid_q, valid_d, stable_q, stable_d;
  logic [7:0]        reject_cnt_q, reject_cnt_d;

  logic              ring_we, ring_clr;
  logic [PW-1:0]     oldest;
  logic [PW:0]       diff;
  logic [PW-1:0]     tol;
  logic              is_reject;
  logic [SW:0]       avg_full;

  period_ring_buffer #(
    .Width    (PW),
    .Log2Depth(LOG2_N)
  ) u_ring (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clr_i   (ring_clr || !en),
    .we_i    (ring_we),
    .wdata_i (cap_q),
    .oldest_o(oldest)
  );

  // period_out_q cannot change between capture and decision, so comparing at t+1 is
  // equivalent to comparing at capture time.
  always_comb begin
    diff = ({1'b0, cap_q} >= {1'b0, period_out_q}) ? {1'b0, cap_q} - {1'b0, period_out_q}
                                                    : {1'b0, period_out_q} - {1'b0, cap_q};
    tol       = period_out_q >> TOL_SHIFT;
    is_reject = OutlierEn && (state_q == StTrack) && (diff > {1'b0, tol});
    avg_full  = ({1'b0, sum_q} + (SW + 1)'(N / 2)) >> LOG2_N;
  end

  always_comb begin
    state_d      = state_q;
    sum_d        = sum_q;
    fill_cnt_d   = fill_cnt_q;
    acc_run_d    = acc_run_q;
    rej_run_d    = rej_run_q;
    cap_d        = cap_q;
    s1_d         = 1'b0;
    s2_d         = 1'b0;
    upd_d        = 1'b0;
    rej_d        = 1'b0;
    set_stable_d = 1'b0;
    ring_we      = 1'b0;
    ring_clr     = 1'b0;
    period_out_d = period_out_q;
    valid_d      = 1'b0;
    stable_d     = stable_q;
    reject_cnt_d = reject_cnt_q;

    // Capture: zero samples never occupy the pipeline.
    if (bus.period_valid && !(s1_q || s2_q) && (bus.period_in != '0)) begin
      s1_d  = 1'b1;
      cap_d = bus.period_in;
    end

    // Decide. The ring reads zero for unwritten slots, so one sum update serves both states.
    if (s1_q) begin
      s2_d = 1'b1;
      if (is_reject) begin
        rej_d     = 1'b1;
        acc_run_d = '0;
        if (rej_run_q == 8'(N - 1)) begin
          ring_clr   = 1'b1;
          sum_d      = '0;
          fill_cnt_d = '0;
          rej_run_d  = '0;
          state_d    = StFill;
        end else begin
          rej_run_d = rej_run_q + 8'd1;
        end
      end else begin
        ring_we   = 1'b1;
        sum_d     = sum_q - SW'(oldest) + SW'(cap_q);
        rej_run_d = '0;
        if (state_q == StFill) begin
          fill_cnt_d = fill_cnt_q + 1'b1;
          if (&fill_cnt_q) begin
            state_d   = StTrack;
            acc_run_d = '0;
            upd_d     = 1'b1;
          end
        end else begin
          upd_d = 1'b1;
          if (acc_run_q < 8'(STABLE_CNT)) acc_run_d = acc_run_q + 8'd1;
          set_stable_d = (acc_run_d == 8'(STABLE_CNT));
        end
      end
    end

    // Publish.
    if (s2_q) begin
      if (upd_q) begin
        period_out_d = (|avg_full[SW:PW]) ? '1 : avg_full[PW-1:0];
        valid_d      = 1'b1;
      end
      if (set_stable_q) stable_d = 1'b1;
      if (rej_q) begin
        stable_d = 1'b0;
        if (reject_cnt_q != 8'hFF) reject_cnt_d = reject_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      state_q      <= StFill;
      sum_q        <= '0;
      fill_cnt_q   <= '0;
      acc_run_q    <= '0;
      rej_run_q    <= '0;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      cap_q        <= '0;
      upd_q        <= 1'b0;
      rej_q        <= 1'b0;
      set_stable_q <= 1'b0;
      period_out_q <= '0;
      valid_q      <= 1'b0;
      stable_q     <= 1'b0;
      reject_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      sum_q        <= sum_d;
      fill_cnt_q   <= fill_cnt_d;
      acc_run_q    <= acc_run_d;
      rej_run_q    <= rej_run_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      cap_q        <= cap_d;
      upd_q        <= upd_d;
      rej_q        <= rej_d;
      set_stable_q <= set_stable_d;
      period_out_q <= period_out_d;
      valid_q      <= valid_d;
      stable_q     <= stable_d;
      reject_cnt_q <= reject_cnt_d;
    end
  end

  assign bus.period_out       = period_out_q;
  assign bus.period_out_valid = valid_q;
  assign bus.stable           = stable_q;
  assign bus.reject_cnt       = reject_cnt_q;

endmodule

// File: tb/tb_period_averager.sv
// Bench for period_averager: a queue-based window model checked every cycle, directed
// scenarios pinned with literal expectations, then randomized strobes/enables/resets.
module tb_period_averager;
  localparam int unsigned PW   = 18;
  localparam int unsigned N    = 8;
  localparam int unsigned TOLS = 4;
  localparam int unsigned SCNT = 4;
`ifdef PERIOD_AVG_OUTLIER_EN
  localparam bit OUTLIER = 1'b1;
`else
  localparam bit OUTLIER = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  period_averager_if #(.PW(PW)) bus ();

  period_averager #(
    .PW        (PW),
    .LOG2_N    (3),
    .TOL_SHIFT (TOLS),
    .STABLE_CNT(SCNT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int unsigned win[$];
  bit          trk;
  int unsigned m_out, m_rej, acc_run, rej_run;
  bit          m_valid, m_stable;
  longint      edge_n = 0;
  longint      last_cap = -100;
  bit          pend;
  longint      pend_at;
  bit          p_upd, p_rej;
  int          p_stab;  // 0 none, 1 set, 2 clear
  int unsigned p_out;

  function automatic int unsigned win_avg();
    longint s = 0;
    foreach (win[i]) s += win[i];
    return int'((s + N / 2) / N);
  endfunction

  task automatic model_reset();
    win.delete();
    trk = 0; m_out = 0; m_rej = 0; acc_run = 0; rej_run = 0;
    m_valid = 0; m_stable = 0; pend = 0; last_cap = -100;
  endtask

  task automatic decide(input int unsigned v);
    longint d;
    d = longint'(v) - longint'(m_out);
    if (d < 0) d = -d;
    p_upd = 0; p_rej = 0; p_stab = 0;
    if (!trk) begin
      win.push_back(v);
      rej_run = 0;
      if (win.size() == N) begin
        trk = 1; acc_run = 0; p_upd = 1; p_out = win_avg();
      end
    end else if (OUTLIER && d > longint'(m_out >> TOLS)) begin
      p_rej = 1; p_stab = 2; acc_run = 0; rej_run++;
      if (rej_run == N) begin
        win.delete(); trk = 0; rej_run = 0;
      end
    end else begin
      void'(win.pop_front());
      win.push_back(v);
      rej_run = 0; acc_run++; p_upd = 1; p_out = win_avg();
      if (acc_run >= SCNT) p_stab = 1;
    end
    pend = 1; pend_at = edge_n + 2;
  endtask

  // Model step on every edge, then compare all outputs just after it.
  always @(posedge clk) begin
    edge_n++;
    if (!rst_n || !en) begin
      model_reset();
    end else begin
      m_valid = 0;
      if (pend && edge_n == pend_at) begin
        pend = 0;
        if (p_upd) begin m_out = p_out; m_valid = 1; end
        if (p_stab == 1) m_stable = 1;
        if (p_stab == 2) m_stable = 0;
        if (p_rej && m_rej < 255) m_rej++;
      end
      if (bus.period_valid && bus.period_in != 0 && edge_n - last_cap >= 3) begin
        decide(bus.period_in);
        last_cap = edge_n;
      end
    end
    #1;
    check("cyc_period_out", bus.period_out, m_out);
    check("cyc_out_valid", bus.period_out_valid, m_valid);
    check("cyc_stable", bus.stable, m_stable);
    check("cyc_reject_cnt", bus.reject_cnt, m_rej);
  end

  // ---------------- stimulus ----------------
  // Called at a negedge; returns at the negedge just before the edge 4 cycles later.
  task automatic send(input int unsigned v);
    bus.period_valid = 1'b1;
    bus.period_in    = PW'(v);
    @(negedge clk);
    bus.period_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_outs(input string tag, input int unsigned out, input bit stab,
                          input int unsigned rej);
    check({tag, "_out"}, bus.period_out, out);
    check({tag, "_stable"}, bus.stable, stab);
    check({tag, "_rej"}, bus.reject_cnt, rej);
  endtask

  initial begin
    int unsigned base;
    int unsigned r;
    bus.period_valid = 1'b0;
    bus.period_in    = '0;
    repeat (3) @(negedge clk);
    chk_outs("reset", 0, 0, 0);
    check("reset_valid", bus.period_out_valid, 0);
    rst_n = 1'b1;

    // Fill, with exact first-output latency on the 8th sample.
    repeat (7) send(1000);
    check("fill_out_held", bus.period_out, 0);
    bus.period_valid = 1'b1;
    bus.period_in    = PW'(1000);
    @(posedge clk); #1;
    check("lat_e0_valid", bus.period_out_valid, 0);
    @(negedge clk);
    bus.period_valid = 1'b0;
    @(posedge clk); #1;
    check("lat_e1_valid", bus.period_out_valid, 0);
    @(posedge clk); #1;
    check("lat_e2_valid", bus.period_out_valid, 1);
    chk_outs("first_avg", 1000, 0, 0);
    repeat (2) @(negedge clk);
    repeat (3) send(1000);
    check("pre_stable", bus.stable, 0);
    send(1000);
    check("stable_set", bus.stable, 1);

    // Tolerance boundary around 1000 (tol 62).
    send(1063);
    if (OUTLIER) chk_outs("tol_1063", 1000, 0, 1);
    else         chk_outs("tol_1063", 1008, 1, 0);
    repeat (4) send(1000);
    send(1062);
    if (OUTLIER) chk_outs("tol_1062", 1008, 1, 1);
    else         chk_outs("tol_1062", 1016, 1, 0);

    // en low one cycle, including mid-FILL, then rounding 8004/8 -> 1001.
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    chk_outs("en_clear", 0, 0, 0);
    repeat (3) send(1000);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    repeat (7) send(1000);
    check("refill_out_held", bus.period_out, 0);
    send(1004);
    chk_outs("round", 1001, 0, 0);

    // Relock to 2000.
    repeat (8) send(2000);
    if (OUTLIER) chk_outs("relock_rej", 1001, 0, 8);
    else         chk_outs("relock_rej", 2000, 1, 0);
    repeat (8) send(2000);
    check("relock_out", bus.period_out, 2000);
    if (OUTLIER) check("relock_unstable", bus.stable, 0);
    repeat (4) send(2000);
    check("relock_stable", bus.stable, 1);

    // Back-to-back strobes: only the first is processed (16014/8 -> 2001).
    bus.period_valid = 1'b1;
    bus.period_in    = PW'(2010);
    @(negedge clk);
    bus.period_in = PW'(9999);
    repeat (2) @(negedge clk);
    bus.period_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk_outs("drop", 2001, 1, OUTLIER ? 8 : 0);
    send(0);
    send(0);
    chk_outs("zero", 2001, 1, OUTLIER ? 8 : 0);

    // Reset while stable.
    rst_n = 1'b0;
    @(negedge clk);
    chk_outs("rst_stable", 0, 0, 0);
    rst_n = 1'b1;

    // Randomized traffic; the per-cycle compare does the checking.
    base = 1000;
    for (int i = 0; i < 4000; i++) begin
      if (i % 400 == 0) base = $urandom_range(500, 120000);
      rst_n = ($urandom_range(0, 999) != 0);
      en    = ($urandom_range(0, 249) != 0);
      r     = $urandom_range(0, 99);
      bus.period_valid = (r < 40);
      if (r < 30)      bus.period_in = PW'(base - base / 16 + $urandom_range(0, base / 8));
      else if (r < 35) bus.period_in = PW'(base * 2);
      else             bus.period_in = '0;
      @(negedge clk);
    end
    bus.period_valid = 1'b0;
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
